// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//
// Pipeline sequencing for the 5-stage MIPS core. This block makes every stall,
// bubble and flush decision for the pipeline registers:
//   - load-use stalls (load in EX feeding the instruction in ID),
//   - branch-in-ID operand stalls that forwarding cannot cover,
//   - a full freeze while a MEM-stage UART access waits for io_ack, with a
//     timeout so that a UART which never answers cannot hang the core.
// It also keeps a saturating count of PC-stall cycles for debug.
//
// Parameters:
//   IO_TIMEOUT   maximum WAIT cycles before an unanswered UART access is
//                abandoned (2..255)
//   CNT_W        width of the stall-cycle counter
//
// Ports:
//   clk, rst                          clock; synchronous active-high reset
//   id_ex_mem_read/reg_write/dst_reg  instruction in EX: load, writes RF, rd
//   ex_mem_mem_read/dst_reg           instruction in MEM: load, rd
//   if_id_rs/rt, id_uses_rs/rt        source operands of the instruction in ID
//   id_is_branch, id_branch_taken     ID branch/jr needing operands; taken
//   ex_mem_io_access, io_ack          MEM touches the UART; UART completion
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
//   ex_mem_write, mem_wb_flush        pipeline register enables and bubbles
//   io_req, io_timeout                UART request; abandoned-access pulse
//   stall_cycles                      saturating count of pc_write=0 cycles
//
// All hazard outputs are combinational from inputs and the current state.

module hazard_stall_controller #(
    parameter int unsigned IO_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       id_ex_dst_reg,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_dst_reg,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             ex_mem_io_access,
    input  logic             io_ack,

    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             io_req,
    output logic             io_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // WAIT-cycle counter only ever has to reach IO_TIMEOUT-1.
    localparam int unsigned TmoW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StTmo  = 2'd2
    } io_state_e;

    io_state_e         state_q;
    logic [TmoW-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    // ------------------------------------------------------------------
    // Operand match detection
    // ------------------------------------------------------------------

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic operand_match(input logic       uses,
                                           input logic [4:0] src,
                                           input logic [4:0] dst);
        return uses && (src == dst) && (dst != 5'd0);
    endfunction

    logic match_ex;
    logic match_mem;
    logic load_use;
    logic branch_haz;

    always_comb begin
        match_ex  = operand_match(id_uses_rs, if_id_rs, id_ex_dst_reg) ||
                    operand_match(id_uses_rt, if_id_rt, id_ex_dst_reg);
        match_mem = operand_match(id_uses_rs, if_id_rs, ex_mem_dst_reg) ||
                    operand_match(id_uses_rt, if_id_rt, ex_mem_dst_reg);

        load_use  = id_ex_mem_read && match_ex;

        // A branch compares in ID, so it needs an ALU result one cycle
        // earlier than EX forwarding gives, and load data two cycles earlier:
        // the second load stall is caught here when the load sits in MEM.
        branch_haz = id_is_branch &&
                     ((id_ex_reg_write && match_ex) ||
                      (ex_mem_mem_read && match_mem));
    end

    // ------------------------------------------------------------------
    // UART access freeze
    // ------------------------------------------------------------------

    logic io_stall;
    logic io_req_raw;

    always_comb begin
        io_stall   = 1'b0;
        io_req_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                io_stall   = ex_mem_io_access;
                io_req_raw = ex_mem_io_access;
            end
            StWait: begin
                // The final WAIT cycle (ack or timeout) lets MEM advance.
                io_stall   = !io_ack && (wait_cnt_q < TmoLast);
                io_req_raw = 1'b1;
            end
            StTmo: begin
                io_stall   = 1'b0;
                io_req_raw = 1'b0;
            end
            default: begin
                io_stall   = 1'b0;
                io_req_raw = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs, in priority order
    // ------------------------------------------------------------------

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        io_req       = io_req_raw;
        io_timeout   = (state_q == StTmo);

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            io_req       = 1'b0;
            io_timeout   = 1'b0;
        end else if (io_stall) begin
            // Whole front end frozen; MEM result must not retire twice.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (load_use || branch_haz) begin
            // Hold PC and IF_ID, inject a bubble into EX.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end else begin
            if_id_flush  = id_branch_taken;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (rst) begin
            // Abandons any in-flight access silently (no timeout pulse).
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ex_mem_io_access) begin
                        state_q    <= StWait;
                        wait_cnt_q <= '0;
                    end
                end
                StWait: begin
                    if (io_ack) begin
                        state_q <= StIdle;
                    end else if (wait_cnt_q == TmoLast) begin
                        state_q <= StTmo;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TmoW'(1);
                    end
                end
                StTmo: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
